// File: rtl/router_out_drain.sv
// router_out_drain: read-side drain controller for one router output port.
// Pops the port FIFO, delineates packets, checks parity, streams bytes out.
module router_out_drain #(
  parameter int SKID_DEPTH = 2,
  parameter int WARN_LIMIT = 24
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  output logic       read_enb,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_sop,
  output logic       m_eop,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       pkt_abort,
  output logic       stall_warn
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    HDR = 2'd0,
    PAY = 2'd1,
    PAR = 2'd2
  } state_t;

  // skid storage (data path only, no reset needed)
  logic [7:0] dat_mem [SKID_DEPTH];
  logic       sop_mem [SKID_DEPTH];
  logic       eop_mem [SKID_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          inflight_q, inflight_d;
  state_t        state_q, state_d;
  logic [5:0]    rem_q, rem_d;
  logic [7:0]    xor_q, xor_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          abort_q, abort_d;
  logic [4:0]    stall_q, stall_d;

  logic          push;
  logic          pop;
  logic          tag_sop;
  logic          tag_eop;
  logic [CW:0]   need;

  // stream outputs come straight from the skid head
  always_comb begin
    m_valid = (occ_q != '0);
    m_data  = m_valid ? dat_mem[rd_ptr_q] : 8'h00;
    m_sop   = m_valid ? sop_mem[rd_ptr_q] : 1'b0;
    m_eop   = m_valid ? eop_mem[rd_ptr_q] : 1'b0;
  end

  // FIFO pop request: only when the skid can absorb the returning byte
  always_comb begin
    pop  = m_valid & m_ready;
    need = {1'b0, occ_q}
         + (CW+1)'(inflight_q)
         - (CW+1)'(pop);
    read_enb = resetn & vld_out & ~soft_reset
             & (need < (CW+1)'(SKID_DEPTH));
  end

  assign push       = inflight_q & ~soft_reset;
  assign tag_sop    = (state_q == HDR);
  assign tag_eop    = (state_q == PAR);
  assign pkt_done   = done_q;
  assign parity_err = err_q;
  assign pkt_abort  = abort_q;
  assign stall_warn = (stall_q >= 5'(WARN_LIMIT));

  // next-state: skid pointers, packet FSM, pulses and stall counter
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    state_d    = state_q;
    rem_d      = rem_q;
    xor_d      = xor_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    abort_d    = 1'b0;
    inflight_d = read_enb;
    stall_d    = stall_q;

    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      state_d  = HDR;
      rem_d    = '0;
      xor_d    = '0;
      abort_d  = (state_q != HDR) | (occ_q != '0);
    end else begin
      if (push) begin
        if (wr_ptr_q == PW'(SKID_DEPTH - 1)) wr_ptr_d = '0;
        else wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        if (rd_ptr_q == PW'(SKID_DEPTH - 1)) rd_ptr_d = '0;
        else rd_ptr_d = rd_ptr_q + 1'b1;
      end
      occ_d = occ_q + CW'(push) - CW'(pop);

      if (push) begin
        unique case (state_q)
          HDR: begin
            rem_d   = data_out[7:2];
            xor_d   = data_out;
            state_d = (data_out[7:2] != 6'd0) ? PAY : PAR;
          end
          PAY: begin
            rem_d   = rem_q - 6'd1;
            xor_d   = xor_q ^ data_out;
            state_d = (rem_q == 6'd1) ? PAR : PAY;
          end
          PAR: begin
            done_d  = 1'b1;
            err_d   = (data_out != xor_q);
            xor_d   = '0;
            state_d = HDR;
          end
          default: state_d = HDR;
        endcase
      end
    end

    if (soft_reset | ~vld_out | read_enb) stall_d = '0;
    else if (stall_q != 5'd31) stall_d = stall_q + 5'd1;
  end

  // control state, cleared asynchronously
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      state_q    <= HDR;
      rem_q      <= '0;
      xor_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      stall_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
      rem_q      <= rem_d;
      xor_q      <= xor_d;
      done_q     <= done_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
      stall_q    <= stall_d;
    end
  end

  // capture the returning FIFO byte with its packet tags
  always_ff @(posedge clock) begin
    if (push) begin
      dat_mem[wr_ptr_q] <= data_out;
      sop_mem[wr_ptr_q] <= tag_sop;
      eop_mem[wr_ptr_q] <= tag_eop;
    end
  end

endmodule

// File: tb/tb_router_out_drain.sv
// tb_router_out_drain: scoreboard bench for router_out_drain.
// FIFO source model, stream scoreboard, occupancy/stall reference model.
module tb_router_out_drain;

  localparam int DEPTH = 2;
  localparam int WARN  = 24;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic       soft_reset = 1'b0;
  logic       m_ready = 1'b0;
  logic       read_enb;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sop;
  logic       m_eop;
  logic       pkt_done;
  logic       parity_err;
  logic       pkt_abort;
  logic       stall_warn;

  router_out_drain #(
    .SKID_DEPTH(DEPTH),
    .WARN_LIMIT(WARN)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .soft_reset(soft_reset),
    .read_enb  (read_enb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .pkt_done  (pkt_done),
    .parity_err(parity_err),
    .pkt_abort (pkt_abort),
    .stall_warn(stall_warn)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } ent_t;

  ent_t       expq[$];
  bit         errq[$];
  logic [7:0] src[$];

  int total = 0;
  int bad = 0;
  int mocc = 0;
  int minfl = 0;
  int scnt = 0;
  int abort_cnt = 0;
  int done_cnt = 0;
  int abort_base = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(logic [7:0] d, logic s, logic e, bit track);
    ent_t x;
    src.push_back(d);
    if (track) begin
      x.d = d;
      x.s = s;
      x.e = e;
      expq.push_back(x);
    end
    vld_out = 1'b1;
  endtask

  task automatic send(logic [7:0] hdr, logic [7:0] base, bit bad_par,
                      bit track);
    logic [7:0] p;
    logic [7:0] b;
    int len;
    len = int'(hdr[7:2]);
    p = hdr;
    push_byte(hdr, 1'b1, 1'b0, track);
    for (int i = 0; i < len; i++) begin
      b = 8'(int'(base) * (i + 1));
      p = p ^ b;
      push_byte(b, 1'b0, 1'b0, track);
    end
    if (bad_par) p = p ^ 8'h01;
    push_byte(p, 1'b0, 1'b1, track);
    if (track) errq.push_back(bad_par);
  endtask

  // one clock: check at negedge, then update FIFO model after posedge
  task automatic cyc();
    bit   ev;
    bit   pop;
    bit   erd;
    bit   rd;
    bit   eb;
    int   room;
    ent_t e;
    @(negedge clock);
    ev = (mocc != 0);
    check("m_valid", m_valid, ev);
    pop = ev & m_ready;
    room = mocc + minfl - (pop ? 1 : 0);
    erd = vld_out & ~soft_reset & resetn & (room < DEPTH);
    check("read_enb", read_enb, erd);
    check("stall_warn", stall_warn, (scnt >= WARN));
    if (pop) begin
      if (expq.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        e = expq.pop_front();
        check("m_data", m_data, e.d);
        check("m_sop", m_sop, e.s);
        check("m_eop", m_eop, e.e);
      end
    end
    if (pkt_done) begin
      done_cnt++;
      if (errq.size() == 0) begin
        check("done_spurious", 1, 0);
      end else begin
        eb = errq.pop_front();
        check("parity_err", parity_err, eb);
      end
    end else begin
      check("perr_idle", parity_err, 0);
    end
    if (pkt_abort) abort_cnt++;
    if (soft_reset || !resetn) mocc = 0;
    else mocc = mocc + minfl - (pop ? 1 : 0);
    minfl = erd;
    if (soft_reset || !vld_out || erd || !resetn) scnt = 0;
    else if (scnt < 31) scnt = scnt + 1;
    rd = read_enb;
    @(posedge clock);
    #1;
    if (rd && src.size() != 0) data_out = src.pop_front();
    vld_out = (src.size() != 0);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (expq.size() == 0 && src.size() == 0 && mocc == 0 && minfl == 0)
        return;
      cyc();
    end
    check("drain_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    vld_out = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_read_enb", read_enb, 0);
    check("rst_abort", pkt_abort, 0);
    check("rst_warn", stall_warn, 0);
    vld_out = 1'b0;
    resetn = 1'b1;
    m_ready = 1'b1;

    // clean packet, L=3
    send(8'h0D, 8'h11, 1'b0, 1'b1);
    drain();
    // same packet, corrupted parity byte 0x0C
    send(8'h0D, 8'h11, 1'b1, 1'b1);
    drain();
    // zero-length packet
    send(8'h02, 8'h00, 1'b0, 1'b1);
    drain();

    // short backpressure mid-payload
    send(8'h14, 8'h10, 1'b0, 1'b1);
    run(3);
    m_ready = 1'b0;
    run(10);
    check("warn_bp10", stall_warn, 0);
    m_ready = 1'b1;
    drain();

    // long backpressure crosses the warn threshold
    send(8'hA0, 8'h03, 1'b0, 1'b1);
    m_ready = 1'b0;
    run(30);
    check("warn_bp30", stall_warn, 1);
    m_ready = 1'b1;
    drain();
    check("warn_clear", stall_warn, 0);

    // soft_reset mid-payload, then a clean packet
    push_byte(8'h0D, 1'b1, 1'b0, 1'b1);
    push_byte(8'h11, 1'b0, 1'b0, 1'b1);
    push_byte(8'h22, 1'b0, 1'b0, 1'b1);
    drain();
    soft_reset = 1'b1;
    cyc();
    soft_reset = 1'b0;
    check("abort_pulse", pkt_abort, 1);
    check("abort_mvalid", m_valid, 0);
    cyc();
    check("abort_width", pkt_abort, 0);
    soft_reset = 1'b1;
    cyc();
    soft_reset = 1'b0;
    check("abort_idle", pkt_abort, 0);
    send(8'h06, 8'hAA, 1'b0, 1'b1);
    drain();

    // async reset with full skid, then a clean packet
    m_ready = 1'b0;
    send(8'h0D, 8'h11, 1'b0, 1'b0);
    run(4);
    check("pre_rst_sop", m_sop, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_read_enb", read_enb, 0);
    check("arst_m_data", m_data, 0);
    check("arst_m_sop", m_sop, 0);
    check("arst_m_eop", m_eop, 0);
    check("arst_done", pkt_done, 0);
    check("arst_perr", parity_err, 0);
    check("arst_abort", pkt_abort, 0);
    check("arst_warn", stall_warn, 0);
    src.delete();
    vld_out = 1'b0;
    data_out = 8'h00;
    mocc = 0;
    minfl = 0;
    scnt = 0;
    abort_base = abort_cnt;
    run(2);
    resetn = 1'b1;
    m_ready = 1'b1;
    send(8'h09, 8'h5A, 1'b0, 1'b1);
    drain();
    run(2);
    check("no_abort", abort_cnt, abort_base);

    check("sb_left", expq.size(), 0);
    check("err_left", errq.size(), 0);
    check("done_count", done_cnt, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_out_drain.md
Name: router_out_drain

Overview:
- Read-side controller for one router output port; one instance per destination FIFO.
- Drains the output FIFO by driving read_enb whenever the FIFO reports valid data and the downstream sink has room.
- Delineates packets (header / payload / parity), checks parity and forwards bytes on a valid/ready stream.
- Reacts to the per-port soft_reset: aborts the current packet and flushes its buffers. Warns before the router's 30-cycle soft-reset timeout can fire.

Parameters:
- SKID_DEPTH, 2, output buffer entries. Must be at least 2 for full throughput with the 1-cycle FIFO read latency.
- WARN_LIMIT, 24, consecutive stalled cycles (vld_out=1, read_enb=0) at which stall_warn asserts. Must be below 30.

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- vld_out  in  1  FIFO non-empty
- data_out  in  8  FIFO read data; valid the cycle after read_enb=1
- soft_reset  in  1  router has flushed this port's FIFO
- read_enb  out  1  FIFO pop request
- m_valid  out  1  stream byte valid
- m_ready  in  1  sink accepts byte when m_valid & m_ready
- m_data  out  8  stream byte
- m_sop  out  1  m_data is a header byte
- m_eop  out  1  m_data is a parity byte
- pkt_done  out  1  1-cycle pulse: parity byte captured
- parity_err  out  1  1-cycle pulse coincident with pkt_done when parity mismatches
- pkt_abort  out  1  1-cycle pulse: packet in progress discarded by soft_reset
- stall_warn  out  1  level: stall counter >= WARN_LIMIT

Behaviour:
- Reset (resetn=0, asynchronous):
  - All outputs 0, skid empty, inflight=0.
  - FSM=HDR, stall counter 0, running XOR 0.
  - Reset mid-packet discards everything. No pkt_abort is generated.
- Packet format:
  - Header: bits [7:2] = payload length L (0..63), bits [1:0] = address (ignored here).
  - Then L payload bytes.
  - Then 1 parity byte = XOR of the header and all payload bytes.
- Read issue:
  - read_enb = vld_out & ~soft_reset & (occ + inflight - pop < SKID_DEPTH), combinational.
  - occ = skid entries; pop = m_valid & m_ready.
  - inflight register = previous-cycle read_enb.
  - Sustains 1 byte/cycle when m_ready=1.
- Capture:
  - When inflight=1 and no soft_reset, data_out is written to the skid at the clock edge, tagged with sop/eop from the FSM.
  - Latency: read_enb at cycle t, m_valid at t+2.
- FSM, advancing on each capture:
  - HDR: load remaining=L and xor=header, tag sop. Go to PAY if L>0, else PAR.
  - PAY: xor ^= byte, remaining -= 1. Go to PAR when remaining reaches 0.
  - PAR: tag eop, pulse pkt_done next cycle. Pulse parity_err with it if byte != xor. Go to HDR.
- Output stream:
  - m_data/m_sop/m_eop come from the skid head; m_valid = occ != 0.
  - Outputs are held stable while m_valid & ~m_ready.
  - FIFO order is preserved. Simultaneous push and pop is legal.
- soft_reset=1 in a cycle:
  - read_enb forced 0 and any inflight byte discarded.
  - At the edge: skid flushed (m_valid=0 next cycle), FSM to HDR, xor cleared, stall counter cleared.
  - pkt_abort pulses next cycle if the FSM was not in HDR or the skid was non-empty. Otherwise no pulse.
- Stall counter:
  - Increments (saturating at 31) each cycle with vld_out=1 & read_enb=0.
  - Clears on read_enb=1, vld_out=0 or soft_reset.
  - stall_warn = counter >= WARN_LIMIT.
- vld_out dropping mid-packet: read_enb goes to 0 and the FSM holds state. This is not an error.

Test Plan:
1. Header 0x0D (L=3), payload 0x11, 0x22, 0x33, parity 0x0D, m_ready=1:
   - read_enb high 5 consecutive cycles.
   - m_data 0D,11,22,33,0D on consecutive cycles starting t+2.
   - m_sop on 0x0D header only, m_eop on last byte.
   - pkt_done pulse, parity_err=0.
2. Same packet with parity byte 0x0C -> pkt_done and parity_err pulse in the same cycle; the byte is still forwarded with m_eop.
3. Backpressure:
   - m_ready=0 for 10 cycles mid-payload -> read_enb drops once occ+inflight=2; no byte lost or duplicated after release; stall_warn stays 0.
   - m_ready=0 for 30 cycles with vld_out=1 -> stall_warn rises on the 24th stalled cycle.
4. soft_reset pulse after 2 payload bytes captured -> next cycle m_valid=0 and pkt_abort=1 for one cycle; a following packet 0x06, 0xAA, 0xAC streams correctly with m_sop on 0x06.
5. Header 0x02 (L=0) followed by parity 0x02 -> m_sop on the first byte, m_eop on the second, parity_err=0.
6. resetn asserted asynchronously mid-packet with skid full -> all outputs 0 immediately; after release, a clean packet is delivered correctly and no pkt_abort pulse occurs.
